pipe_gap_gen: RTL and testbench
===============================

# pipe_gap_gen

Consumer end of the game's pseudo-random source: periodically samples the 13-bit LFSR word, reduces it to a legal pipe-gap height, limits the height step relative to the previous pipe, and offers the result to the pipe-scroller over a valid/ready handshake. It sits between the LFSR and the pipe-scroller in the Flappy Bird game logic.

## Interface
Parameters:
- SPAWN_TICKS, 90: frame ticks between the end of one offer and the next sample.
- GAP_MIN, 64: smallest gap top Y, in pixels.
- GAP_RANGE, 256: number of legal gap positions. Power of two not required.
- MAX_STEP, 96: maximum absolute Y change between consecutive gaps.
- RESAMPLE_CLKS, 16: clocks to wait before resampling a stale LFSR word.
- Legality: GAP_MIN+GAP_RANGE ≤ 1024; all parameters ≥ 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clock frame-tick pulse.
- enable  in  1  game running; low = idle/new game.
- rnd  in  13  LFSR output word.
- pipe_ready  in  1  scroller accepts the offered gap.
- pipe_valid  out  1  gap offer valid.
- pipe_gap_y  out  10  gap top Y.
- spawn_count  out  8  accepted gaps since reset; wraps 255→0.

## Operation
- States: IDLE, WAIT, SAMPLE, RESAMPLE, REDUCE, CLAMP, OFFER.
- IDLE: tick counter=0, have_prev=0, retry=0. enable=1 → WAIT.
- WAIT: counts tick pulses. The tick that brings the count to SPAWN_TICKS → SAMPLE. Ticks in any other state are ignored. The counter is cleared on every entry to WAIT.
- SAMPLE: work←rnd.
  - If have_prev, rnd==last_rnd and retry<3: retry++, → RESAMPLE.
  - Otherwise: retry←0, → REDUCE.
- RESAMPLE: waits RESAMPLE_CLKS clocks, then → SAMPLE.
- REDUCE: one step per clock. If work ≥ GAP_RANGE, work←work−GAP_RANGE. Otherwise → CLAMP. Width is 13 bits unsigned; no wrap is possible.
- CLAMP: cand = GAP_MIN+work.
  - If have_prev and cand > prev+MAX_STEP: gap←prev+MAX_STEP.
  - Else if have_prev and cand+MAX_STEP < prev: gap←prev−MAX_STEP.
  - Else: gap←cand.
  - Compares use 11-bit intermediates. Then → OFFER.
- OFFER: pipe_valid=1 and pipe_gap_y is stable until accepted. On pipe_ready=1 in the same clock:
  - prev←gap, last_rnd←sampled word, have_prev←1, spawn_count++.
  - → WAIT.
- enable=0 in any state: → IDLE on the next clock, pipe_valid=0, and any pending offer is abandoned. This is the only case where valid drops without ready.
- Reset values: pipe_valid=0, pipe_gap_y=0, spawn_count=0. Internal state: state=IDLE, prev=0, last_rnd=0, have_prev=0, retry=0.

## Timing
- Outputs are registered. pipe_gap_y is updated on entry to OFFER and holds afterwards.
- Latency without resample: pipe_valid rises n+3 clocks after the edge that samples the final tick, where n=floor(rnd/GAP_RANGE).
  - Worst case at defaults: n=31, giving 34 clocks.
- Each resample adds RESAMPLE_CLKS+1 clocks. There are at most 3 resamples per spawn; after the third, the stale word is used.
- Handshake: the transfer occurs on the clock where valid&ready=1. The next offer appears no sooner than SPAWN_TICKS ticks later.
- pipe_ready while valid=0 is ignored.
- tick coinciding with the reset clock is ignored.
- Reset has priority over enable; enable has priority over all transitions.

## Test plan
- Reset with enable=1, then release reset → pipe_valid=0, pipe_gap_y=0, spawn_count=0 until SPAWN_TICKS ticks have elapsed.
- SPAWN_TICKS=4, rnd=13'h0105, pipe_ready=1 → after the 4th tick, valid rises 4 clocks later (n=1) with gap_y=69; spawn_count=1.
- No previous gap, rnd=13'h1FFF → n=31, gap_y=319, valid 34 clocks after the final tick.
- prev=69 and rnd=13'h00FF → gap_y=165 (upward clamp). Then prev=165 and rnd=13'h0000 → gap_y=69 (downward clamp, cand 64).
- rnd held equal to last_rnd → three 17-clock resample loops, then offer with the clamped stale value. Variant: rnd changes during the second wait → the new value is used and retry is cleared.
- pipe_ready=0 for 50 clocks → valid/gap held stable and spawn_count unchanged. Then drop enable → valid=0 next clock, and the next gap after re-enable is unclamped (have_prev=0).

Source files
------------

// File: rtl/pipe_gap_gen.sv
// pipe_gap_gen: samples the LFSR word, reduces it to a legal gap height with a
// limited step from the previous gap, and offers it over valid/ready.
module pipe_gap_gen #(
    parameter int SPAWN_TICKS   = 90,
    parameter int GAP_MIN       = 64,
    parameter int GAP_RANGE     = 256,
    parameter int MAX_STEP      = 96,
    parameter int RESAMPLE_CLKS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        enable,
    input  logic [12:0] rnd,
    input  logic        pipe_ready,
    output logic        pipe_valid,
    output logic [9:0]  pipe_gap_y,
    output logic [7:0]  spawn_count
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT     = 3'd1;
    localparam logic [2:0] SAMPLE   = 3'd2;
    localparam logic [2:0] RESAMPLE = 3'd3;
    localparam logic [2:0] REDUCE   = 3'd4;
    localparam logic [2:0] CLAMP    = 3'd5;
    localparam logic [2:0] OFFER    = 3'd6;
    localparam int CW = $clog2((SPAWN_TICKS > RESAMPLE_CLKS ? SPAWN_TICKS : RESAMPLE_CLKS) + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [12:0]   work_q, work_d, samp_q, samp_d, last_q, last_d;
    logic [9:0]    prev_q, prev_d, gap_q, gap_d;
    logic [1:0]    retry_q, retry_d;
    logic          have_q, have_d, valid_q, valid_d;
    logic [7:0]    spawn_q, spawn_d;
    logic [10:0]   cand, hi, cand_up;
    logic [9:0]    clamped;

    // Shared counter: frame ticks in WAIT, clocks in RESAMPLE.
    always_comb begin
        cand    = 11'(GAP_MIN) + work_q[10:0];
        hi      = {1'b0, prev_q} + 11'(MAX_STEP);
        cand_up = cand + 11'(MAX_STEP);
        clamped = !have_q ? cand[9:0] : cand > hi ? hi[9:0] :
                  cand_up < {1'b0, prev_q} ? prev_q - 10'(MAX_STEP) : cand[9:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        samp_d  = samp_q;
        last_d  = last_q;
        prev_d  = prev_q;
        gap_d   = gap_q;
        retry_d = retry_q;
        have_d  = have_q;
        valid_d = valid_q;
        spawn_d = spawn_q;
        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
            have_d  = 1'b0;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
                WAIT: if (tick) begin
                    state_d = cnt_q == CW'(SPAWN_TICKS - 1) ? SAMPLE : WAIT;
                    cnt_d   = cnt_q + CW'(1);
                end
                SAMPLE: begin
                    work_d = rnd;
                    samp_d = rnd;
                    if (have_q && rnd == last_q && retry_q != 2'd3) begin
                        retry_d = retry_q + 2'd1;
                        cnt_d   = '0;
                        state_d = RESAMPLE;
                    end else begin
                        retry_d = 2'd0;
                        state_d = REDUCE;
                    end
                end
                RESAMPLE: begin
                    state_d = cnt_q == CW'(RESAMPLE_CLKS - 1) ? SAMPLE : RESAMPLE;
                    cnt_d   = cnt_q + CW'(1);
                end
                REDUCE: begin
                    state_d = work_q >= 13'(GAP_RANGE) ? REDUCE : CLAMP;
                    work_d  = work_q >= 13'(GAP_RANGE) ? work_q - 13'(GAP_RANGE) : work_q;
                end
                CLAMP: begin
                    gap_d   = clamped;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
                OFFER: if (pipe_ready) begin
                    prev_d  = gap_q;
                    last_d  = samp_q;
                    have_d  = 1'b1;
                    spawn_d = spawn_q + 8'd1;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            samp_q  <= '0;
            last_q  <= '0;
            prev_q  <= '0;
            gap_q   <= '0;
            retry_q <= 2'd0;
            have_q  <= 1'b0;
            valid_q <= 1'b0;
            spawn_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            samp_q  <= samp_d;
            last_q  <= last_d;
            prev_q  <= prev_d;
            gap_q   <= gap_d;
            retry_q <= retry_d;
            have_q  <= have_d;
            valid_q <= valid_d;
            spawn_q <= spawn_d;
        end
    end

    assign pipe_valid  = valid_q;
    assign pipe_gap_y  = gap_q;
    assign spawn_count = spawn_q;
endmodule

// File: tb/tb_pipe_gap_gen.sv
// tb_pipe_gap_gen: directed and randomized spawns checked against an
// arithmetic model of gap reduction, step clamping, stale resampling and latency.
module tb_pipe_gap_gen;
    localparam int SP = 4;
    localparam int GM = 64;
    localparam int GR = 256;
    localparam int MS = 96;
    localparam int RC = 16;

    logic        clock = 1'b0;
    logic        reset, tick, enable, pipe_ready;
    logic [12:0] rnd;
    logic        pipe_valid;
    logic [9:0]  pipe_gap_y;
    logic [7:0]  spawn_count;

    int vectors = 0;
    int miscompares = 0;
    bit have = 1'b0;
    int prev = 0;
    int last = 0;
    int spawns = 0;

    pipe_gap_gen #(.SPAWN_TICKS(SP), .GAP_MIN(GM), .GAP_RANGE(GR), .MAX_STEP(MS), .RESAMPLE_CLKS(RC)) dut (
        .clock(clock), .reset(reset), .tick(tick), .enable(enable), .rnd(rnd),
        .pipe_ready(pipe_ready), .pipe_valid(pipe_valid), .pipe_gap_y(pipe_gap_y),
        .spawn_count(spawn_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1;
        @(posedge clock);
        #1;
    endtask

    function automatic int model_gap(int w, bit h, int p);
        int g;
        g = GM + w % GR;
        if (h && g > p + MS) g = p + MS;
        else if (h && g < p - MS) g = p - MS;
        return g;
    endfunction

    // Runs one spawn: ticks, resample/reduce wait, offer held for 'hold' clocks,
    // then either accepted or abandoned by dropping enable.
    task automatic spawn(input int old_w, input int new_w, input int change_at, input int hold, input bit drop);
        int k, used, egap, elat, lat, t;
        rnd = 13'(old_w);
        pipe_ready = 1'b1;
        for (int i = 0; i < SP; i++) begin
            chk("valid_before_tick", pipe_valid, 0);
            tick = 1'b1;
            clk1();
            tick = 1'b0;
            repeat (i == SP - 1 ? 0 : $urandom_range(0, 2)) clk1();
        end
        pipe_ready = 1'b0;
        chk("count_ready_ignored", spawn_count, spawns & 255);
        k = 0;
        t = 1;
        while (k < 3 && have && ((t > change_at) ? new_w : old_w) == last) begin
            k++;
            t = 1 + (RC + 1) * k;
        end
        used = (t > change_at) ? new_w : old_w;
        egap = model_gap(used, have, prev);
        elat = (RC + 1) * k + used / GR + 3;
        lat = 0;
        do begin
            clk1();
            lat++;
            if (lat == change_at) rnd = 13'(new_w);
        end while (!pipe_valid && lat < 300);
        chk("latency", lat, elat);
        chk("gap_y", pipe_gap_y, egap);
        chk("count_in_offer", spawn_count, spawns & 255);
        for (int i = 0; i < hold; i++) begin
            rnd = 13'($urandom);
            clk1();
            chk("hold_valid", pipe_valid, 1);
            chk("hold_gap", pipe_gap_y, egap);
            chk("hold_count", spawn_count, spawns & 255);
        end
        if (drop) begin
            enable = 1'b0;
            clk1();
            chk("drop_valid", pipe_valid, 0);
            chk("drop_count", spawn_count, spawns & 255);
            have = 1'b0;
            enable = 1'b1;
            clk1();
        end else begin
            pipe_ready = 1'b1;
            clk1();
            pipe_ready = 1'b0;
            spawns++;
            chk("accept_valid", pipe_valid, 0);
            chk("accept_count", spawn_count, spawns & 255);
            have = 1'b1;
            prev = egap;
            last = used;
        end
    endtask

    initial begin
        int w;
        reset = 1'b1;
        enable = 1'b1;
        tick = 1'b1;
        pipe_ready = 1'b1;
        rnd = 13'h0105;
        repeat (3) begin
            clk1();
            chk("rst_valid", pipe_valid, 0);
            chk("rst_gap", pipe_gap_y, 0);
            chk("rst_count", spawn_count, 0);
        end
        reset = 1'b0;
        tick = 1'b0;
        pipe_ready = 1'b0;
        clk1();
        chk("post_rst_valid", pipe_valid, 0);
        chk("post_rst_gap", pipe_gap_y, 0);

        spawn(13'h0105, 13'h0105, 10000, 0, 1'b0);
        chk("first_gap_const", prev, 69);
        spawn(13'h00FF, 13'h00FF, 10000, 1, 1'b0);
        chk("up_clamp_const", prev, 165);
        spawn(13'h0000, 13'h0000, 10000, 0, 1'b0);
        chk("down_clamp_const", prev, 69);
        spawn(last, last, 10000, 0, 1'b0);
        spawn(last, 13'h0ABC, 20, 2, 1'b0);
        chk("resample_new_const", prev, 160);
        spawn(13'h0777, 13'h0777, 10000, 50, 1'b1);
        spawn(13'h1FFF, 13'h1FFF, 10000, 0, 1'b0);
        chk("unclamped_const", prev, 319);

        for (int i = 0; i < 25; i++) begin
            w = ($urandom_range(0, 3) == 0) ? last : int'($urandom_range(0, 8191));
            if ($urandom_range(0, 2) == 0)
                spawn(w, int'($urandom_range(0, 8191)), int'($urandom_range(1, 60)), int'($urandom_range(0, 3)), 1'b0);
            else
                spawn(w, w, 10000, int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
